// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The table functions run only while parameters are resolved. They are
// never used to search at runtime.
package seq_det_pkg;

    localparam int unsigned MAX_PAT_W = 16;

    // Width of the matched-prefix register. It holds values 0..pat_w-1.
    function automatic int unsigned prefix_w(input int unsigned pat_w);
        return (pat_w <= 2) ? 1 : $clog2(pat_w);
    endfunction

    // Mask of the k least-significant bits (k <= 16).
    function automatic int unsigned low_mask(input int unsigned k);
        return (32'd1 << k) - 32'd1;
    endfunction

    // Longest proper border of the pattern: the longest k < pat_w for which
    // the first k bits equal the last k bits. The pattern is MSB-first, so the
    // first k bits are pat >> (pat_w-k) and the last k bits are pat & mask(k).
    function automatic int unsigned border_len(input int unsigned pat,
                                               input int unsigned pat_w);
        for (int unsigned k = pat_w - 1; k >= 1; k--) begin
            if ((pat & low_mask(k)) == (pat >> (pat_w - k)))
                return k;
        end
        return 0;
    endfunction

    // Prefix length after consuming bit x while p bits are already matched.
    // The window is the matched prefix with x appended. The result is the
    // longest window suffix that is also a pattern prefix. A complete match
    // either restarts from the border or from zero.
    function automatic int unsigned next_prefix(input int unsigned pat,
                                                input int unsigned pat_w,
                                                input int unsigned p,
                                                input int unsigned x,
                                                input bit          overlap);
        int unsigned win;
        int unsigned len;
        len = p + 1;
        win = ((pat >> (pat_w - p)) << 1) | (x & 32'd1);
        if (p == 0)
            win = x & 32'd1;
        for (int unsigned k = len; k >= 1; k--) begin
            if ((win & low_mask(k)) == (pat >> (pat_w - k))) begin
                if (k == pat_w)
                    return overlap ? border_len(pat, pat_w) : 0;
                return k;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating match counter. It stops at all-ones and never wraps.
module seq_det_sat_cnt
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    assign sat = (cnt == '1);

    // Count events. A clear wins over an increment, and the count holds once saturated.
    always_ff @(posedge clk or negedge res) begin
        if (!res)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector. It tracks the KMP prefix length, emits a
// registered match pulse, and counts matches in a saturating counter.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         en,
    input  logic                         x,
    input  logic                         clr,
    output logic                         t1,
    output logic                         t2,
    output logic [prefix_w(PAT_W)-1:0]   prefix,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat
);

    localparam int unsigned PW     = prefix_w(PAT_W);
    localparam int unsigned NSTATE = 1 << PW;
    localparam int unsigned PAT32  = 32'(PATTERN);

    localparam logic [PW-1:0] P_IDLE = '0;
    localparam logic [PW-1:0] P_LAST = PW'(PAT_W - 1);

    logic [PW-1:0] p;
    logic [PW-1:0] nxt_tbl [NSTATE][2];
    logic          hit;
    logic          inc;

    // Next-state table, fully constant. Encodings that are never reached
    // (p >= PAT_W) map to idle so the table is total.
    for (genvar gp = 0; gp < NSTATE; gp++) begin : g_p
        for (genvar gx = 0; gx < 2; gx++) begin : g_x
            if (gp < PAT_W) begin : g_live
                assign nxt_tbl[gp][gx] = PW'(next_prefix(PAT32, PAT_W, gp, gx, OVERLAP));
            end else begin : g_dead
                assign nxt_tbl[gp][gx] = P_IDLE;
            end
        end
    end

    // The last pattern bit arrives while the rest of the pattern is already matched.
    assign hit = (p == P_LAST) && (x == PATTERN[0]);

    // Count on the same edge that raises t1. A clear on that edge discards both.
    assign inc = en && !clr && hit;

    assign prefix = p;
    assign t2     = (p != P_IDLE);

    // Prefix state and registered match pulse.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            p  <= P_IDLE;
            t1 <= 1'b0;
        end else if (clr) begin
            p  <= P_IDLE;
            t1 <= 1'b0;
        end else if (en) begin
            p  <= nxt_tbl[p][x];
            t1 <= hit;
        end else begin
            t1 <= 1'b0;
        end
    end

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .res (res),
        .clr (clr),
        .inc (inc),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector. Three instances share one stimulus stream:
// the defaults, OVERLAP=0, and CNT_W=2. The reference model keeps a window of
// consumed bits and derives the prefix and matches directly from the pattern.
module tb_seq_detector;

    localparam int unsigned W   = 4;
    localparam int unsigned PAT = 4'b1011;
    localparam bit          OVL  [3] = '{1'b1, 1'b0, 1'b1};
    localparam int unsigned CMAX [3] = '{255, 255, 3};

    typedef struct {
        int unsigned h;    // consumed bits, newest in bit 0
        int unsigned len;  // number of valid bits in h, capped at W
        int unsigned cnt;
        bit          t1;
    } mdl_t;

    logic clk = 1'b0;
    logic res, en, x, clr;

    logic       t1_a, t2_a, sat_a;
    logic [1:0] pfx_a;
    logic [7:0] cnt_a;
    logic       t1_b, t2_b, sat_b;
    logic [1:0] pfx_b;
    logic [7:0] cnt_b;
    logic       t1_c, t2_c, sat_c;
    logic [1:0] pfx_c;
    logic [1:0] cnt_c;

    int   n_checks = 0;
    int   n_fail   = 0;
    mdl_t m [3];

    always #5 clk = ~clk;

    seq_detector dut_a (
        .clk(clk), .res(res), .en(en), .x(x), .clr(clr),
        .t1(t1_a), .t2(t2_a), .prefix(pfx_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_detector #(.OVERLAP(1'b0)) dut_b (
        .clk(clk), .res(res), .en(en), .x(x), .clr(clr),
        .t1(t1_b), .t2(t2_b), .prefix(pfx_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    seq_detector #(.CNT_W(2)) dut_c (
        .clk(clk), .res(res), .en(en), .x(x), .clr(clr),
        .t1(t1_c), .t2(t2_c), .prefix(pfx_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Longest k < W such that the last k consumed bits equal the first k pattern bits.
    function automatic int unsigned mdl_prefix(input mdl_t s);
        for (int k = W - 1; k >= 1; k--) begin
            if (s.len >= k && (s.h & ((1 << k) - 1)) == (PAT >> (W - k)))
                return k;
        end
        return 0;
    endfunction

    function automatic mdl_t mdl_edge(input mdl_t s, input bit e, input bit xb, input bit c,
                                      input bit ovl, input int unsigned cmax);
        mdl_t n;
        n    = s;
        n.t1 = 1'b0;
        if (c) begin
            n.h = 0; n.len = 0; n.cnt = 0;
        end else if (e) begin
            n.h   = ((s.h << 1) | xb) & 32'hFFFF;
            n.len = (s.len < W) ? s.len + 1 : W;
            if (n.len >= W && (n.h & ((1 << W) - 1)) == PAT) begin
                n.t1 = 1'b1;
                if (n.cnt < cmax) n.cnt++;
                if (!ovl) begin
                    n.h = 0; n.len = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.h = 0; n.len = 0; n.cnt = 0; n.t1 = 1'b0;
        return n;
    endfunction

    task automatic check_dut(input string tag, input int i, input logic t1v, input logic t2v,
                             input logic [1:0] pv, input int unsigned cv, input logic sv);
        int unsigned ep;
        ep = mdl_prefix(m[i]);
        check({tag, "_t1"},  t1v, m[i].t1);
        check({tag, "_pfx"}, pv,  ep);
        check({tag, "_t2"},  t2v, (ep != 0) ? 1 : 0);
        check({tag, "_cnt"}, cv,  m[i].cnt);
        check({tag, "_sat"}, sv,  (m[i].cnt == CMAX[i]) ? 1 : 0);
    endtask

    task automatic check_all(input string tag);
        check_dut({tag, "_a"}, 0, t1_a, t2_a, pfx_a, cnt_a, sat_a);
        check_dut({tag, "_b"}, 1, t1_b, t2_b, pfx_b, cnt_b, sat_b);
        check_dut({tag, "_c"}, 2, t1_c, t2_c, pfx_c, cnt_c, sat_c);
    endtask

    task automatic step(input bit e, input bit xb, input bit c, input string tag);
        en = e; x = xb; clr = c;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            m[i] = mdl_edge(m[i], e, xb, c, OVL[i], CMAX[i]);
        check_all(tag);
    endtask

    task automatic reset_models();
        for (int i = 0; i < 3; i++)
            m[i] = mdl_reset();
    endtask

    initial begin
        logic [6:0] s33;
        logic [3:0] s35;
        int unsigned exp35 [4];
        s33 = 7'b1011011;
        s35 = 4'b1010;
        exp35 = '{1, 2, 3, 2};

        res = 1'b0; en = 1'b0; x = 1'b0; clr = 1'b0;
        reset_models();
        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        #3 res = 1'b1;

        // Overlapping and non-overlapping on the same stream.
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s33[i], 1'b0, "s33");
            if (i == 3) begin
                check("s33_bit4_a", t1_a, 1);
                check("s33_bit4_b", t1_b, 1);
            end
        end
        check("s33_bit7_a", t1_a, 1);
        check("s33_bit7_b", t1_b, 0);
        check("s33_cnt_a", cnt_a, 2);
        check("s33_cnt_b", cnt_b, 1);
        check("s33_pfx_b", pfx_b, 1);

        // Mismatch fallback.
        step(1'b0, 1'b0, 1'b1, "clr");
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, s35[i], 1'b0, "s35");
            check("s35_pfx", pfx_a, exp35[3 - i]);
            check("s35_t1", t1_a, 0);
        end

        // Enable gaps hold the prefix.
        step(1'b0, 1'b0, 1'b1, "clr");
        step(1'b1, 1'b1, 1'b0, "s36");
        step(1'b1, 1'b0, 1'b0, "s36");
        step(1'b1, 1'b1, 1'b0, "s36");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, "s36_hold");
            check("s36_hold_pfx", pfx_a, 3);
            check("s36_hold_t1", t1_a, 0);
        end
        step(1'b1, 1'b1, 1'b0, "s36");
        check("s36_final_t1", t1_a, 1);

        // Counter saturation on the narrow instance.
        step(1'b0, 1'b0, 1'b1, "clr");
        step(1'b1, 1'b1, 1'b0, "s37");
        for (int r = 0; r < 5; r++) begin
            if (r > 0) step(1'b1, 1'b0, 1'b0, "s37");
            else       step(1'b1, 1'b0, 1'b0, "s37");
            step(1'b1, 1'b1, 1'b0, "s37");
            step(1'b1, 1'b1, 1'b0, "s37");
            check("s37_t1", t1_c, 1);
            check("s37_sat", sat_c, (r >= 2) ? 1 : 0);
        end
        check("s37_cnt", cnt_c, 3);
        step(1'b0, 1'b0, 1'b1, "s37_clr");
        check("s37_clr_cnt", cnt_c, 0);
        check("s37_clr_sat", sat_c, 0);

        // A match arriving together with clear is discarded.
        step(1'b1, 1'b1, 1'b0, "s25");
        step(1'b1, 1'b0, 1'b0, "s25");
        step(1'b1, 1'b1, 1'b0, "s25");
        step(1'b1, 1'b1, 1'b1, "s25_clr");
        check("s25_t1", t1_a, 0);
        check("s25_cnt", cnt_a, 0);

        // Asynchronous reset in the middle of a partial match.
        step(1'b1, 1'b1, 1'b0, "s38");
        step(1'b1, 1'b0, 1'b0, "s38");
        step(1'b1, 1'b1, 1'b0, "s38");
        check("s38_pre_pfx", pfx_a, 3);
        #3 res = 1'b0;
        #1;
        reset_models();
        check_all("s38_async");
        #2 res = 1'b1;
        step(1'b1, 1'b1, 1'b0, "s38");
        step(1'b1, 1'b0, 1'b0, "s38");
        step(1'b1, 1'b1, 1'b0, "s38");
        step(1'b1, 1'b1, 1'b0, "s38");
        check("s38_cnt", cnt_a, 1);
        check("s38_t1", t1_a, 1);
        // Reset while t1 is high.
        #3 res = 1'b0;
        #1;
        reset_models();
        check("s38_t1_async", t1_a, 0);
        check_all("s38_async2");
        #2 res = 1'b1;

        // Random stream.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 49) == 0), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: PAT_W-bit pattern; the MSB is matched first.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 res  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  sample enable; x is consumed only on an edge where en=1.
REQ-008 x  input  1  serial data bit.
REQ-009 clr  input  1  synchronous clear of detector state and counter.
REQ-010 t1  output  1  registered match pulse.
REQ-011 t2  output  1  partial-match flag: high when prefix != 0.
REQ-012 prefix  output  $clog2(PAT_W)  current matched-prefix length, 0..PAT_W-1.
REQ-013 match_cnt  output  CNT_W  saturating count of matches.
REQ-014 cnt_sat  output  1  high while match_cnt equals all-ones.

Function
REQ-015 The state SHALL be prefix P, the length of the longest pattern prefix that is also a suffix of the bits consumed so far.
REQ-016 On an edge with en=1, clr=0: if x equals PATTERN[PAT_W-1-P] and P+1<PAT_W, P SHALL become P+1.
REQ-017 When x completes the pattern (P=PAT_W-1 with a matching bit), t1 SHALL be 1 for exactly the next cycle.
REQ-018 After a completed match, P SHALL become the longest proper border of PATTERN if OVERLAP=1, and 0 if OVERLAP=0.
REQ-019 On a mismatch, P SHALL become the longest suffix of (matched prefix, x) that is a pattern prefix, per standard KMP fallback.
REQ-020 Next-state values SHALL come from a table computed at elaboration for all (P, x) pairs; no runtime search.
REQ-021 Latency: t1 and prefix reflect the sampled bit one clock after the sampling edge.
REQ-022 On an edge with en=0, P, match_cnt and cnt_sat SHALL hold, and t1 SHALL be 0.
REQ-023 On each t1 pulse, match_cnt SHALL increment by 1 and stop at 2^CNT_W-1; it SHALL never wrap.
REQ-024 clr=1 SHALL force P=0, t1=0 and match_cnt=0 on the next edge, taking priority over en and x.
REQ-025 If a match completes on the same edge as clr=1, the match is discarded: no pulse and no count.
REQ-026 t2 SHALL be combinational from the registered P.

Reset
REQ-027 res=0 SHALL immediately force P=0, t1=0, t2=0, match_cnt=0 and cnt_sat=0, regardless of clk.
REQ-028 Reset during a partial match SHALL discard the partial match; detection restarts from P=0 after res is released.
REQ-029 Reset deassertion is synchronised externally; the block SHALL NOT require a synchroniser.

Structure
REQ-030 Package seq_det_pkg SHALL hold the border and next-state table functions and the prefix-width constant function.
REQ-031 The saturating counter SHALL be the sub-module seq_det_sat_cnt (parameter CNT_W; ports clk, res, clr, inc, cnt, sat).
REQ-032 The FSM and the t1 register SHALL reside in seq_detector.

Verification
REQ-033 Defaults, OVERLAP=1, en=1, stream 1,0,1,1,0,1,1 -> t1 after bits 4 and 7; match_cnt=2.
REQ-034 OVERLAP=0, same stream -> t1 after bit 4 only; match_cnt=1; P after bit 7 = 1.
REQ-035 Stream 1,0,1,0 -> prefix 1,2,3,2 (mismatch fallback); t1 never asserts.
REQ-036 Stream 1,0,1 then en=0 for 3 cycles with x=0, then en=1 with x=1 -> prefix holds at 3; t1 after the final bit.
REQ-037 CNT_W=2, 5 matches -> match_cnt=3, cnt_sat=1 from the third match on; clr -> 0,0 next edge.
REQ-038 prefix=3, res pulsed low mid-cycle -> prefix=0, t1=0 asynchronously; then 1,0,1,1 -> one match.
